// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the 640x480 VGA raster path: default timing (pixel
// clocks / lines), derived totals and active-area start offsets, the default
// colour-stage read latency, and the counter/colour/address widths.
// -----------------------------------------------------------------------------
package vga_pkg;

  // Horizontal timing, in pixel clocks; region order from count 0 is
  // sync, back porch, active, front porch.
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_H_FRONT = 16;

  // Vertical timing, in lines, same region order.
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_V_FRONT = 10;

  // Read latency of the downstream colour stage (legal 1..7).
  localparam int DEF_PIPE_DLY = 2;

  localparam int DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACT + DEF_H_FRONT;
  localparam int DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACT + DEF_V_FRONT;
  localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BACK;

  localparam int CNT_W   = 10;  // H/V counters and X/Y
  localparam int COLOR_W = 10;  // DAC colour channel
  localparam int ADDR_W  = 19;  // linear frame-buffer address (640*480 < 2^19)

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth shift register used to realign raster side-band signals
// (sync, blank, optionally X) with the colour stage's read latency.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset; every stage loads RST_VAL
//   din    in   WIDTH  value entering the line
//   dout   out  WIDTH  din delayed by DEPTH clocks
// -----------------------------------------------------------------------------
module vga_delay_line #(
  parameter int                 WIDTH   = 1,
  parameter int                 DEPTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // NOTE: every stage is reset, not just the output; a mid-frame reset must
  // not let stale sync/blank values drain out after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Pixel-clock raster engine for the 640x480 VGA path. Produces H/V counters,
// the registered active-area X/Y/address request to the OSD/frame-buffer read
// stage, and realigns sync/blank to that stage's PIPE_DLY read latency before
// driving the DAC.
//   iVGA_CLK      in   pixel clock
//   iRST_N        in   asynchronous active-low reset
//   oVGA_X/Y      out  active-area column/row (0 outside the active area)
//   oVGA_ADDR     out  linear pixel address Y*H_ACT+X
//   oRequest      out  high while X/Y/ADDR address an active pixel
//   iRed/Green/Blue in colour from the read stage, PIPE_DLY after oRequest
//   oVGA_R/G/B    out  DAC colour, forced to 0 while blanked
//   oVGA_HS/VS    out  active-low syncs
//   oVGA_BLANK_n  out  low outside the active area
//   oVGA_SYNC_n   out  sync-on-green, held at 1
// Build option: define VGA_TEST_PATTERN_EN to replace the input colour with
// eight 80-pixel vertical colour bars (X is then carried through a delay line).
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACT    = DEF_H_ACT,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACT    = DEF_V_ACT,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic               iVGA_CLK,
  input  logic               iRST_N,
  output logic [CNT_W-1:0]   oVGA_X,
  output logic [CNT_W-1:0]   oVGA_Y,
  output logic [ADDR_W-1:0]  oVGA_ADDR,
  output logic               oRequest,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_HS,
  output logic               oVGA_VS,
  output logic               oVGA_BLANK_n,
  output logic               oVGA_SYNC_n
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;

  localparam logic [CNT_W-1:0]  H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_START    = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0]  H_END      = CNT_W'(H_SYNC + H_BACK + H_ACT);
  localparam logic [CNT_W-1:0]  V_START    = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0]  V_END      = CNT_W'(V_SYNC + V_BACK + V_ACT);
  localparam logic [CNT_W-1:0]  H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0]  V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_active, v_active, pix_active;
  logic             hs_req, vs_req;
  logic             hs_dly, vs_dly, blank_dly;
  logic [COLOR_W-1:0] r_sel, g_sel, b_sel;

  // ---------------------------------------------------------------- counters
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, whatever the statement order.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_ONE;
    end else begin
      h_cnt <= h_cnt + CNT_ONE;
    end
  end

  always_comb begin
    h_active   = (h_cnt >= H_START) && (h_cnt < H_END);
    v_active   = (v_cnt >= V_START) && (v_cnt < V_END);
    pix_active = h_active && v_active;
  end

  // ----------------------------------------------------------- request stage
  // Raw syncs are registered alongside oRequest so sync and blank share one
  // alignment through the delay line.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oRequest  <= 1'b0;
      oVGA_X    <= '0;
      oVGA_Y    <= '0;
      oVGA_ADDR <= '0;
      hs_req    <= 1'b0;
      vs_req    <= 1'b0;
    end else begin
      oRequest <= pix_active;
      oVGA_X   <= pix_active ? h_cnt - H_START : '0;
      oVGA_Y   <= pix_active ? v_cnt - V_START : '0;
      hs_req   <= (h_cnt < H_SYNC_END);
      vs_req   <= (v_cnt < V_SYNC_END);
      // Address advances after each requested pixel, so it already points at
      // the next pixel while blanked and holds until the next active run.
      if (h_cnt == '0 && v_cnt == '0) oVGA_ADDR <= '0;
      else if (oRequest)              oVGA_ADDR <= oVGA_ADDR + ADDR_ONE;
    end
  end

  // ------------------------------------------------------- alignment delays
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL (3'b000)
  ) u_sync_dly (
    .clk   (iVGA_CLK),
    .rst_n (iRST_N),
    .din   ({hs_req, vs_req, oRequest}),
    .dout  ({hs_dly, vs_dly, blank_dly})
  );

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_PX = CNT_W'(80);

  logic [CNT_W-1:0] x_dly;
  logic [2:0]       bar;

  vga_delay_line #(
    .WIDTH   (CNT_W),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({CNT_W{1'b0}})
  ) u_x_dly (
    .clk   (iVGA_CLK),
    .rst_n (iRST_N),
    .din   (oVGA_X),
    .dout  (x_dly)
  );

  assign bar = 3'(x_dly / BAR_PX);
`endif

  // ------------------------------------------------------------ output mux
  // NOTE: defaults first, so no path through this block leaves a colour
  // unassigned and infers a latch.
  always_comb begin
    r_sel = '0;
    g_sel = '0;
    b_sel = '0;
    if (blank_dly) begin
`ifdef VGA_TEST_PATTERN_EN
      r_sel = {COLOR_W{bar[2]}};
      g_sel = {COLOR_W{bar[1]}};
      b_sel = {COLOR_W{bar[0]}};
`else
      r_sel = iRed;
      g_sel = iGreen;
      b_sel = iBlue;
`endif
    end
  end

  // Final register: colour and the delayed sync/blank land on the same edge,
  // PIPE_DLY+1 clocks after the matching oRequest.
  always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_R       <= '0;
      oVGA_G       <= '0;
      oVGA_B       <= '0;
      oVGA_HS      <= 1'b1;
      oVGA_VS      <= 1'b1;
      oVGA_BLANK_n <= 1'b0;
      oVGA_SYNC_n  <= 1'b1;
    end else begin
      oVGA_R       <= r_sel;
      oVGA_G       <= g_sel;
      oVGA_B       <= b_sel;
      oVGA_HS      <= ~hs_dly;
      oVGA_VS      <= ~vs_dly;
      oVGA_BLANK_n <= blank_dly;
      oVGA_SYNC_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. One instance uses the default 640x480
// timing with a modelled PIPE_DLY=2 read stage; a second, shrunken raster
// (17x8 clocks, PIPE_DLY=3) exercises frame wrap within a short run.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int PD   = 2;
  localparam int S_PD = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default-timing instance
  logic [9:0]  x, y, red, green, blue, r, g, b;
  logic [18:0] addr;
  logic        req, hs, vs, blank_n, sync_n;

  vga_timing_gen #(.PIPE_DLY(PD)) u_dut (
    .iVGA_CLK(clk), .iRST_N(rst_n),
    .oVGA_X(x), .oVGA_Y(y), .oVGA_ADDR(addr), .oRequest(req),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
    .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_n(blank_n), .oVGA_SYNC_n(sync_n)
  );

  // small-raster instance: H 4+3+8+2=17, V 2+2+3+1=8, frame = 136 clocks
  logic [9:0]  s_x, s_y, s_r, s_g, s_b;
  logic [9:0]  s_red = 10'h3FF, s_green = 10'h000, s_blue = 10'h0AA;
  logic [18:0] s_addr;
  logic        s_req, s_hs, s_vs, s_blank, s_sync;

  vga_timing_gen #(
    .H_SYNC(4), .H_BACK(3), .H_ACT(8), .H_FRONT(2),
    .V_SYNC(2), .V_BACK(2), .V_ACT(3), .V_FRONT(1), .PIPE_DLY(S_PD)
  ) u_small (
    .iVGA_CLK(clk), .iRST_N(rst_n),
    .oVGA_X(s_x), .oVGA_Y(s_y), .oVGA_ADDR(s_addr), .oRequest(s_req),
    .iRed(s_red), .iGreen(s_green), .iBlue(s_blue),
    .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
    .oVGA_HS(s_hs), .oVGA_VS(s_vs), .oVGA_BLANK_n(s_blank), .oVGA_SYNC_n(s_sync)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // monitor state
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic        const_mode = 1'b0;
  logic [18:0] addr_hist [8];
  logic [9:0]  x_hist [8];
  logic        req_hist [8];
  logic        s_req_hist [8];
  int col_errs = 0, lat_errs = 0, addr_errs = 0, req_count = 0;
  int hs_run = 0, hs_runs = 0, hs_bad = 0, vs_run = 0, vs_runs = 0, vs_bad = 0;
  int last_req_rise = 0;
  logic prev_req = 1'b0, prev_blank = 1'b0;
  logic [9:0] prev_r = '0;
  logic rise_done = 1'b0;
  int s_errs = 0, s_win_req = 0, s_win_hs = 0, s_win_vs = 0, s_win_first = 0, s_win_last = 0;
  logic [29:0] cap0 = '1, cap80 = '1, cap560 = '1;

  task automatic tick();
    logic [9:0] er, eg, eb, s_er, s_eb;
    logic [2:0] bar;
    @(negedge clk);
    cyc++;
    for (int i = 7; i > 0; i--) begin
      addr_hist[i]  = addr_hist[i-1];
      x_hist[i]     = x_hist[i-1];
      req_hist[i]   = req_hist[i-1];
      s_req_hist[i] = s_req_hist[i-1];
    end
    addr_hist[0] = addr; x_hist[0] = x; req_hist[0] = req; s_req_hist[0] = s_req;
    if (mon_en) begin
`ifdef VGA_TEST_PATTERN_EN
      bar  = 3'(x_hist[PD+1] / 10'd80);
      er   = {10{bar[2]}};
      eg   = {10{bar[1]}};
      eb   = {10{bar[0]}};
      s_er = 10'h000;
      s_eb = 10'h000;
`else
      bar  = 3'd0;
      er   = const_mode ? 10'h3FF : addr_hist[PD+1][9:0];
      eg   = ~er;
      eb   = 10'h155;
      s_er = 10'h3FF;
      s_eb = 10'h0AA;
`endif
      if (blank_n) begin
        if (r != er || g != eg || b != eb) col_errs++;
        if (x_hist[PD+1] == 10'd0)   cap0   = {r, g, b};
        if (x_hist[PD+1] == 10'd80)  cap80  = {r, g, b};
        if (x_hist[PD+1] == 10'd560) cap560 = {r, g, b};
      end else if (r != 0 || g != 0 || b != 0) col_errs++;
      if (sync_n !== 1'b1) col_errs++;
      if (blank_n !== req_hist[PD+1]) lat_errs++;
      if (req) begin
        req_count++;
        if (addr != y * 640 + x || x > 639 || y > 479) addr_errs++;
      end else if (x != 0 || y != 0) addr_errs++;
      if (!hs) hs_run++;
      else begin
        if (hs_run != 0) begin hs_runs++; if (hs_run != 96) hs_bad++; end
        hs_run = 0;
      end
      if (!vs) vs_run++;
      else begin
        if (vs_run != 0) begin vs_runs++; if (vs_run != 1600) vs_bad++; end
        vs_run = 0;
      end
      if (req && !prev_req) last_req_rise = cyc;
`ifndef VGA_TEST_PATTERN_EN
      if (const_mode && !rise_done && blank_n && !prev_blank) begin
        check("const_blank_rise_lat", cyc - last_req_rise, PD + 1);
        check("const_red_at_rise", r, 10'h3FF);
        check("const_red_before_rise", prev_r, 0);
        rise_done = 1'b1;
      end
`endif
      prev_req = req; prev_blank = blank_n; prev_r = r;
      // small raster
      if (s_blank !== s_req_hist[S_PD+1]) s_errs++;
      if (s_blank ? (s_r != s_er || s_g != 0 || s_b != s_eb) : (s_r != 0 || s_g != 0 || s_b != 0)) s_errs++;
      if (s_req && (s_addr != s_y * 8 + s_x || s_x > 7 || s_y > 2)) s_errs++;
      if (cyc >= 1000 && cyc < 1136) begin
        if (s_req) s_win_req++;
        if (!s_hs) s_win_hs++;
        if (!s_vs) s_win_vs++;
        if (s_req && s_x == 0 && s_y == 0 && s_addr == 0)  s_win_first++;
        if (s_req && s_x == 7 && s_y == 2 && s_addr == 23) s_win_last++;
      end
    end
    // read-stage model: returns ADDR issued PD clocks ago
    red   = const_mode ? 10'h3FF : addr_hist[PD][9:0];
    green = ~red;
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_x"}, x, 0);          check({p, "_y"}, y, 0);
    check({p, "_addr"}, addr, 0);    check({p, "_req"}, req, 0);
    check({p, "_r"}, r, 0);          check({p, "_g"}, g, 0);
    check({p, "_b"}, b, 0);          check({p, "_hs"}, hs, 1);
    check({p, "_vs"}, vs, 1);        check({p, "_blank_n"}, blank_n, 0);
    check({p, "_sync_n"}, sync_n, 1);
  endtask

  task automatic run_to_first_req(input string p);
    int guard = 0;
    while (!req && guard < 30000) begin tick(); guard++; end
    check({p, "_first_req_clocks"}, cyc, 35 * 800 + 144 + 1);
    check({p, "_first_x"}, x, 0);
    check({p, "_first_y"}, y, 0);
    check({p, "_first_addr"}, addr, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      addr_hist[i] = '0; x_hist[i] = '0; req_hist[i] = 1'b0; s_req_hist[i] = 1'b0;
    end
    red = '0; green = '1; blue = 10'h155;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst_n = 1'b1;
    cyc = 0;
    mon_en = 1'b1;

    // first active pixel, then the end of that line
    run_to_first_req("por");
    repeat (639) tick();
    check("eol_req", req, 1);
    check("eol_x", x, 639);
    check("eol_addr", addr, 639);
    tick();
    check("eol_next_req", req, 0);
    check("eol_next_addr", addr, 640);

    // constant red from the blanking gap before line Y=1
    while (cyc < 28850) tick();
    const_mode = 1'b1;
    // stop at h_cnt=400 of v_cnt=36
    while (cyc < 29200) tick();

    check("colour_errors", col_errs, 0);
    check("blank_latency_errors", lat_errs, 0);
    check("addr_xy_errors", addr_errs, 0);
    check("request_count", req_count, 640 + 256);
    check("hs_low_runs", hs_runs, 37);
    check("hs_bad_runs", hs_bad, 0);
    check("vs_low_runs", vs_runs, 1);
    check("vs_bad_runs", vs_bad, 0);
`ifdef VGA_TEST_PATTERN_EN
    check("bar_x0_rgb", cap0, 30'h0);
    check("bar_x80_rgb", cap80, 30'h3FF);
    check("bar_x560_rgb", cap560, 30'h3FFF_FFFF);
`else
    check("const_rise_seen", rise_done, 1);
`endif
    check("small_errors", s_errs, 0);
    check("small_req_per_frame", s_win_req, 24);
    check("small_hs_low_per_frame", s_win_hs, 32);
    check("small_vs_low_per_frame", s_win_vs, 34);
    check("small_first_pixel_hits", s_win_first, 1);
    check("small_last_pixel_hits", s_win_last, 1);

    // mid-frame asynchronous reset
    mon_en = 1'b0;
    const_mode = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    run_to_first_req("mid");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
